// File: rtl/alu_bcd_converter.sv
// -----------------------------------------------------------------------------
// alu_bcd_converter
//
// Converts the ALU's registered W-bit unsigned result into packed BCD using a
// sequential shift-and-add-3 (double-dabble) engine. Exactly one conversion is
// in flight at a time. Upstream is stalled while the engine is busy, and the
// finished result is held under downstream backpressure.
//
// Parameters
//   W       binary input width (ALU result width)
//   DIGITS  number of BCD digits; 10**DIGITS must exceed 2**W - 1
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_valid   in_data is valid
//   in_data    unsigned binary value to convert
//   in_ready   converter can accept a value (IDLE only)
//   out_valid  bcd holds a completed conversion (DONE only)
//   out_ready  downstream accepts bcd
//   bcd        packed BCD result, digit 0 (units) in bits [3:0]
//   busy       conversion in progress or result awaiting handshake
// -----------------------------------------------------------------------------
module alu_bcd_converter #(
    parameter int W      = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [W-1:0]          in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       bin_sr_q, bin_sr_d;
    logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W+W-1:0] shifted;

    // Pre-shift correction: any digit >= 5 would become >= 10 after doubling,
    // so add 3 now so the doubling carries cleanly into the next digit.
    function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = v[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        bin_sr_d = bin_sr_q;
        bcd_sr_d = bcd_sr_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;

        adj     = add3_adjust(bcd_sr_q);
        shifted = {adj, bin_sr_q} << 1;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_sr_d = in_data;
                    bcd_sr_d = '0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                bcd_sr_d = shifted[BCD_W+W-1:W];
                bin_sr_d = shifted[W-1:0];
                cnt_d    = cnt_q + CNT_W'(1);
                // Last step: publish the fully shifted digits directly so the
                // result is ready in the same cycle DONE is entered.
                if (cnt_q == CNT_W'(W - 1)) begin
                    bcd_d   = shifted[BCD_W+W-1:W];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bin_sr_q <= '0;
            bcd_sr_q <= '0;
            cnt_q    <= '0;
            bcd_q    <= '0;
        end else begin
            state_q  <= state_d;
            bin_sr_q <= bin_sr_d;
            bcd_sr_q <= bcd_sr_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
        end
    end

    // Handshake outputs decode registered state only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign bcd       = bcd_q;

endmodule

// File: tb/tb_alu_bcd_converter.sv
module tb_alu_bcd_converter;

    localparam int W      = 10;
    localparam int DIGITS = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [W-1:0]      in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [4*DIGITS-1:0] bcd;
    logic              busy;

    int n_vec;
    int n_fail;

    alu_bcd_converter #(.W(W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by repeated division.
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int bcd_value(input logic [15:0] b);
        int s;
        int wgt;
        s = 0;
        wgt = 1;
        for (int k = 0; k < 4; k++) begin
            s = s + int'(b[4*k +: 4]) * wgt;
            wgt = wgt * 10;
        end
        return s;
    endfunction

    function automatic bit digits_ok(input logic [15:0] b);
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (b[4*k +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // All stimulus changes and output sampling happen at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({in_ready, out_valid, busy} !== 3'b100 || bcd !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_hold: got rdy=%b vld=%b busy=%b bcd=%h required rdy=1 vld=0 busy=0 bcd=0000",
                     in_ready, out_valid, busy, bcd);
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if ({in_ready, out_valid, busy} !== 3'b100 || bcd !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b vld=%b busy=%b bcd=%h required rdy=1 vld=0 busy=0 bcd=0000",
                     in_ready, out_valid, busy, bcd);
        end
    endtask

    // Wait (bounded) for out_valid after an accept edge; returns cycles counted.
    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        n_vec++;
        if (lat != W) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles required %0d", name, lat, W);
        end
    endtask

    // One complete conversion starting from IDLE at a falling edge.
    task automatic do_conv(input int val, input int stall, input string name);
        int lat;
        logic [15:0] exp;
        logic [15:0] held;
        exp = to_bcd(val);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_idle: got %b required 1", name, in_ready);
        end
        in_valid  = 1'b1;
        in_data   = W'(val);
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        in_data  = W'($urandom);
        n_vec++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy: got rdy=%b busy=%b required rdy=0 busy=1", name, in_ready, busy);
        end
        wait_valid(name, lat);
        n_vec++;
        if (bcd !== exp || !digits_ok(bcd) || bcd_value(bcd) != val) begin
            n_fail++;
            $display("FAIL %s_bcd: got %h required %h (value %0d)", name, bcd, exp, val);
        end
        held = bcd;
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || bcd !== held || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_stall: got vld=%b bcd=%h rdy=%b required vld=1 bcd=%h rdy=0",
                         name, out_valid, bcd, in_ready, held);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || bcd !== held) begin
            n_fail++;
            $display("FAIL %s_handshake: got vld=%b rdy=%b bcd=%h required vld=0 rdy=1 bcd=%h",
                     name, out_valid, in_ready, bcd, held);
        end
    endtask

    task automatic test_boundary();
        do_conv(0,    0, "bnd_0");
        do_conv(1023, 0, "bnd_1023");
        do_conv(9,    0, "bnd_9");
        do_conv(225,  0, "bnd_225");
    endtask

    task automatic test_backpressure();
        int lat;
        in_valid  = 1'b1;
        in_data   = W'(500);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_valid("bp500", lat);
        for (int s = 0; s < 7; s++) begin
            in_valid = (s % 2 == 0);
            in_data  = W'(3);
            n_vec++;
            if (out_valid !== 1'b1 || bcd !== 16'h0500 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: got vld=%b bcd=%h rdy=%b required vld=1 bcd=0500 rdy=0",
                         out_valid, bcd, in_ready);
            end
            tick();
        end
        in_valid  = 1'b1;
        in_data   = W'(3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== 16'h0500) begin
            n_fail++;
            $display("FAIL bp_release: got rdy=%b vld=%b bcd=%h required rdy=1 vld=0 bcd=0500",
                     in_ready, out_valid, bcd);
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept3: got busy=%b required 1", busy);
        end
        wait_valid("bp3", lat);
        n_vec++;
        if (bcd !== 16'h0003) begin
            n_fail++;
            $display("FAIL bp_bcd3: got %h required 0003", bcd);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int vals[3];
        int acc_cyc[3];
        int cyc;
        int idx;
        int nout;
        bit acc;
        vals = '{99, 100, 512};
        cyc  = 0;
        idx  = 0;
        nout = 0;
        in_valid  = 1'b1;
        in_data   = W'(vals[0]);
        out_ready = 1'b1;
        while (nout < 3 && cyc < 100) begin
            acc = in_ready && in_valid;
            if (out_valid) begin
                n_vec++;
                if (bcd !== to_bcd(vals[nout])) begin
                    n_fail++;
                    $display("FAIL b2b_out%0d: got %h required %h", nout, bcd, to_bcd(vals[nout]));
                end
                nout++;
            end
            tick();
            cyc++;
            if (acc && idx < 3) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 3) in_data = W'(vals[idx]);
                else         in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_vec++;
        if (nout != 3 || idx != 3) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d outputs %0d accepts required 3 and 3", nout, idx);
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_vec++;
                if (acc_cyc[i] - acc_cyc[i-1] != W + 2) begin
                    n_fail++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles required %0d",
                             i, acc_cyc[i] - acc_cyc[i-1], W + 2);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        in_valid  = 1'b1;
        in_data   = W'(777);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int s = 0; s < 5; s++) tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || bcd !== 16'h0000 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: got vld=%b bcd=%h rdy=%b busy=%b required vld=0 bcd=0000 rdy=1 busy=0",
                     out_valid, bcd, in_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || bcd !== 16'h0000) begin
            n_fail++;
            $display("FAIL midrst_after: got vld=%b bcd=%h required vld=0 bcd=0000", out_valid, bcd);
        end
        do_conv(42, 0, "midrst_42");
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 1000; i++) begin
            v = int'($urandom_range(1023, 0));
            do_conv(v, ($urandom_range(3, 0) == 0) ? int'($urandom_range(4, 1)) : 0, "rand");
        end
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        test_reset();
        test_boundary();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
